shift_rows_pipe: RTL

SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

---
 rtl/shift_rows_pipe_if.sv | 25 ++
 rtl/shift_rows_pipe.sv | 123 ++++++++++++
 2 files changed

// File: rtl/shift_rows_pipe_if.sv
// Block stream interface for shift_rows_pipe: input and output valid/ready channels plus the delivered-block count.
interface shift_rows_pipe_if #(
   parameter int unsigned NB = 4
) ();
   localparam int unsigned W = 32 * NB;

   logic         in_valid;
   logic         in_ready;
   logic         in_inv;
   logic [W-1:0] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_state;
   logic [15:0]  blk_cnt;

   modport slave (
      input  in_valid, in_inv, in_state, out_ready,
      output in_ready, out_valid, out_state, blk_cnt
   );

   modport master (
      output in_valid, in_inv, in_state, out_ready,
      input  in_ready, out_valid, out_state, blk_cnt
   );
endinterface

// File: rtl/shift_rows_pipe.sv
// Rijndael ShiftRows / InvShiftRows as a 1- or 2-stage valid/ready pipeline, with the mode selected per block.
module shift_rows_pipe #(
   parameter int unsigned NB     = 4,
   parameter int unsigned REG_IN = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   shift_rows_pipe_if.slave bus
);
   localparam int unsigned W = 32 * NB;

   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
   end
   if (!(REG_IN == 0 || REG_IN == 1)) begin : g_bad_reg_in
      $error("shift_rows_pipe: REG_IN must be 0 or 1");
   end

   // Row offsets: 0,1,2,3 except for 256-bit blocks, where rows 2 and 3 shift by 3 and 4.
   function automatic int unsigned row_shift(input int unsigned r);
      return (NB == 8 && r >= 2) ? r + 1 : r;
   endfunction

   function automatic logic [W-1:0] permute(input logic [W-1:0] st, input logic inv);
      logic [W-1:0] res;
      int unsigned  src;
      res = '0;
      for (int unsigned c = 0; c < NB; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            src = inv ? (c + NB - row_shift(r)) % NB : (c + row_shift(r)) % NB;
            res[8*(4*c+r) +: 8] = st[8*(4*src+r) +: 8];
         end
      end
      return res;
   endfunction

   logic         src_valid;
   logic         src_inv;
   logic [W-1:0] src_state;
   logic         src_take;
   logic         out_drain;
   logic         out_free;

   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_state_q, out_state_d;
   logic [15:0]  blk_cnt_q, blk_cnt_d;

   assign out_drain = out_valid_q && bus.out_ready;
   assign out_free  = !out_valid_q || out_drain;
   assign src_take  = src_valid && out_free;

   if (REG_IN == 1) begin : g_in_reg
      logic         s0_full_q, s0_full_d;
      logic         s0_inv_q, s0_inv_d;
      logic [W-1:0] s0_state_q, s0_state_d;
      logic         s0_load;

      // The input stage drains exactly when the output stage can take it.
      assign bus.in_ready = !s0_full_q || out_free;
      assign s0_load      = bus.in_valid && bus.in_ready;

      always_comb begin
         s0_full_d  = s0_full_q;
         s0_inv_d   = s0_inv_q;
         s0_state_d = s0_state_q;
         if (src_take) s0_full_d = 1'b0;
         if (s0_load) begin
            s0_full_d  = 1'b1;
            s0_inv_d   = bus.in_inv;
            s0_state_d = bus.in_state;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s0_full_q  <= 1'b0;
            s0_inv_q   <= 1'b0;
            s0_state_q <= '0;
         end else begin
            s0_full_q  <= s0_full_d;
            s0_inv_q   <= s0_inv_d;
            s0_state_q <= s0_state_d;
         end
      end

      assign src_valid = s0_full_q;
      assign src_inv   = s0_inv_q;
      assign src_state = s0_state_q;
   end else begin : g_in_pass
      assign bus.in_ready = out_free;
      assign src_valid    = bus.in_valid;
      assign src_inv      = bus.in_inv;
      assign src_state    = bus.in_state;
   end

   // Output stage: one-entry buffer holding the permuted block; reload on drain keeps valid high.
   always_comb begin
      out_valid_d = out_valid_q;
      out_state_d = out_state_q;
      blk_cnt_d   = blk_cnt_q + 16'(out_drain);
      if (out_drain) out_valid_d = 1'b0;
      if (src_take) begin
         out_valid_d = 1'b1;
         out_state_d = permute(src_state, src_inv);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_state_q <= '0;
         blk_cnt_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_state_q <= out_state_d;
         blk_cnt_q   <= blk_cnt_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_state = out_state_q;
   assign bus.blk_cnt   = blk_cnt_q;
endmodule
